// File: rtl/vram_pkg.sv
// Shared types and helpers for the parametrised video DRAM with serial access port.
package vram_pkg;

   localparam int VRAM_MAX_WORD = 512;
   localparam int VRAM_MAX_LANE = 64;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RD_WAIT   = 3'd1,
      ST_RMW_WAIT  = 3'd2,
      ST_RMW_WR    = 3'd3,
      ST_XFER_WAIT = 3'd4,
      ST_PF_WAIT   = 3'd5
   } vram_state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Extracts lane idx of width dw from a zero-extended memory word.
   function automatic logic [VRAM_MAX_LANE-1:0] lane_sel(input logic [VRAM_MAX_WORD-1:0] word,
                                                         input int idx, input int dw);
      return VRAM_MAX_LANE'(word >> (idx * dw)) &
             ((VRAM_MAX_LANE'(1) << dw) - VRAM_MAX_LANE'(1));
   endfunction

endpackage

// File: rtl/vram_sam.sv
// Serial access buffer: holds one memory word, shifts a lane out per SC pulse, flags wrap.
module vram_sam
   import vram_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int LANES    = 4,
   parameter int LB       = 2,
   parameter int PREFETCH = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_ptr_ld,
   input  logic [LB-1:0]           i_start,
   input  logic                    i_load,
   input  logic [LANES*DATA_W-1:0] i_word,
   input  logic                    i_sc,
   output logic [DATA_W-1:0]       o_sd,
   output logic                    o_wrap
);

   logic [LANES*DATA_W-1:0] r_buf;
   logic [LB-1:0]           r_ptr;
   logic [DATA_W-1:0]       r_sd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf <= '0;
         r_ptr <= '0;
         r_sd  <= '0;
      end else begin
         if (i_load) r_buf <= i_word;
         if (i_sc) begin
            r_sd  <= DATA_W'(lane_sel(VRAM_MAX_WORD'(r_buf), int'(r_ptr), DATA_W));
            r_ptr <= r_ptr + 1'b1;
         end
         if (i_ptr_ld) r_ptr <= i_start;
      end
   end

   // Wrap fires as the last lane is consumed; the top turns it into a prefetch request.
   assign o_wrap = i_sc && (r_ptr == LB'(LANES - 1)) && (PREFETCH != 0);
   assign o_sd   = r_sd;

endmodule

// File: rtl/vram_sam_gen.sv
// Video DRAM top: RAS/CAS strobe decode, pending commands, RMW/transfer FSM and word RAM.
module vram_sam_gen
   import vram_pkg::*;
#(
   parameter int AD_W     = 8,
   parameter int DATA_W   = 8,
   parameter int LANES    = 4,
   parameter int PREFETCH = 1,
   parameter int WPB_EN   = 1
) (
   input  logic              MCLK,
   input  logic              RESET_n,
   input  logic              RAS,
   input  logic              CAS,
   input  logic              WE,
   input  logic              OE,
   input  logic              SC,
   input  logic              SE,
   input  logic [AD_W-1:0]   AD,
   input  logic [DATA_W-1:0] RD_i,
   output logic [DATA_W-1:0] RD_o,
   output logic              RD_d,
   output logic [DATA_W-1:0] SD_o,
   output logic              SD_d,
   output logic [2:0]        o_dbg_state
);

   localparam int LB     = clog2(LANES);
   localparam int CW_W   = AD_W - LB;
   localparam int WA_W   = 2 * AD_W - LB;
   localparam int WORD_W = LANES * DATA_W;

   vram_state_t       r_state;
   logic              r_ras_q, r_cas_q, r_oe_q, r_sc_q;
   logic [AD_W-1:0]   r_row, r_col, r_sam_row;
   logic              r_dt;
   logic [DATA_W-1:0] r_mask, r_rd_o;
   logic [WA_W-1:0]   r_cmd_word, r_xfer_word, r_op_word;
   logic [LB-1:0]     r_cmd_lane, r_op_lane;
   logic [CW_W-1:0]   r_pf_word;
   logic              r_xfer_pend, r_pf_pend, r_wr_pend, r_rd_pend, r_valid;
   logic [WORD_W-1:0] r_mem [2**WA_W];
   logic [WORD_W-1:0] r_q;

   logic              w_ras_fall, w_cas_fall, w_oe_rise, w_sc_pulse, w_sam_wrap, w_sam_load;
   logic [WA_W-1:0]   w_sel_word, w_addr;
   logic [DATA_W-1:0] w_old_lane, w_merge;
   logic [LANES-1:0]  w_lane_we;
   logic [WORD_W-1:0] w_wdata;

   assign w_ras_fall = r_ras_q & ~RAS;
   assign w_cas_fall = r_cas_q & ~CAS & ~RAS;
   assign w_oe_rise  = ~r_oe_q & OE & r_dt;
   // An SC edge coinciding with a transfer detect is dropped.
   assign w_sc_pulse = ~r_sc_q & SC & ~w_oe_rise;
   assign w_sam_load = (r_state == ST_XFER_WAIT) || (r_state == ST_PF_WAIT);

   always_comb begin
      w_sel_word = r_cmd_word;
      if (r_xfer_pend)    w_sel_word = r_xfer_word;
      else if (r_pf_pend) w_sel_word = {r_sam_row, r_pf_word};
      w_addr = (r_state == ST_IDLE) ? w_sel_word : r_op_word;
   end

   assign w_old_lane = DATA_W'(lane_sel(VRAM_MAX_WORD'(r_q), int'(r_op_lane), DATA_W));
   assign w_merge    = (w_old_lane & ~r_mask) | (RD_i & r_mask);
   assign w_wdata    = {LANES{w_merge}};
   assign w_lane_we  = (r_state == ST_RMW_WR) ? (LANES'(1) << r_op_lane) : '0;

   always_ff @(posedge MCLK) begin
      r_q <= r_mem[w_addr];
      for (int l = 0; l < LANES; l++)
         if (w_lane_we[l]) r_mem[w_addr][l*DATA_W +: DATA_W] <= w_wdata[l*DATA_W +: DATA_W];
   end

   always_ff @(posedge MCLK or negedge RESET_n) begin
      if (!RESET_n) begin
         r_ras_q     <= 1'b1;
         r_cas_q     <= 1'b1;
         r_oe_q      <= 1'b1;
         r_sc_q      <= 1'b1;
         r_state     <= ST_IDLE;
         r_row       <= '0;
         r_col       <= '0;
         r_sam_row   <= '0;
         r_dt        <= 1'b0;
         r_mask      <= '1;
         r_cmd_word  <= '0;
         r_cmd_lane  <= '0;
         r_xfer_word <= '0;
         r_op_word   <= '0;
         r_op_lane   <= '0;
         r_pf_word   <= '0;
         r_xfer_pend <= 1'b0;
         r_pf_pend   <= 1'b0;
         r_wr_pend   <= 1'b0;
         r_rd_pend   <= 1'b0;
         r_rd_o      <= '0;
         r_valid     <= 1'b0;
      end else begin
         r_ras_q <= RAS;
         r_cas_q <= CAS;
         r_oe_q  <= OE;
         r_sc_q  <= SC;
         if (w_ras_fall) begin
            r_row  <= AD;
            r_dt   <= ~OE;
            r_mask <= (!WE && (WPB_EN != 0)) ? RD_i : '1;
         end
         case (r_state)
            ST_IDLE: begin
               r_op_word <= w_sel_word;
               r_op_lane <= r_cmd_lane;
               if (r_xfer_pend) begin
                  r_xfer_pend <= 1'b0;
                  r_state     <= ST_XFER_WAIT;
               end else if (r_pf_pend) begin
                  r_pf_pend <= 1'b0;
                  r_state   <= ST_PF_WAIT;
               end else if (r_wr_pend) begin
                  r_wr_pend <= 1'b0;
                  r_state   <= ST_RMW_WAIT;
               end else if (r_rd_pend) begin
                  r_rd_pend <= 1'b0;
                  r_state   <= ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               r_rd_o  <= w_old_lane;
               r_valid <= 1'b1;
               r_state <= ST_IDLE;
            end
            ST_RMW_WAIT:  r_state <= ST_RMW_WR;
            ST_RMW_WR:    r_state <= ST_IDLE;
            ST_XFER_WAIT: r_state <= ST_IDLE;
            ST_PF_WAIT: begin
               r_pf_word <= r_pf_word + 1'b1;
               r_state   <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
         if (CAS || OE) r_valid <= 1'b0;
         // New strobes land after the IDLE decision so a repeated command overwrites its flag.
         if (w_cas_fall) begin
            r_col      <= AD;
            r_cmd_word <= {r_row, AD[AD_W-1:LB]};
            r_cmd_lane <= AD[LB-1:0];
            if (!WE && !r_dt)             r_wr_pend <= 1'b1;
            else if (WE && !OE && !r_dt)  r_rd_pend <= 1'b1;
         end
         if (w_sam_wrap) r_pf_pend <= 1'b1;
         if (w_oe_rise) begin
            r_xfer_pend <= 1'b1;
            r_pf_pend   <= 1'b0;
            r_xfer_word <= {r_row, r_col[AD_W-1:LB]};
            r_sam_row   <= r_row;
            r_pf_word   <= CW_W'(r_col[AD_W-1:LB] + 1'b1);
         end
      end
   end

   vram_sam #(
      .DATA_W   (DATA_W),
      .LANES    (LANES),
      .LB       (LB),
      .PREFETCH (PREFETCH)
   ) u_sam (
      .clk      (MCLK),
      .rst_n    (RESET_n),
      .i_ptr_ld (w_oe_rise),
      .i_start  (r_col[LB-1:0]),
      .i_load   (w_sam_load),
      .i_word   (r_q),
      .i_sc     (w_sc_pulse),
      .o_sd     (SD_o),
      .o_wrap   (w_sam_wrap)
   );

   assign RD_o        = r_rd_o;
   assign RD_d        = ~r_valid;
   assign SD_d        = SE;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vram_sam_gen.sv
// Bench for vram_sam_gen: two instances (prefetch+WPB, and neither) driven by identical stimulus.
module tb_vram_sam_gen;
   import vram_pkg::*;

   logic       MCLK, RESET_n, RAS, CAS, WE, OE, SC, SE;
   logic [7:0] AD, RD_i;
   logic [7:0] rd_o_a, sd_o_a, rd_o_b, sd_o_b;
   logic       rd_d_a, sd_d_a, rd_d_b, sd_d_b;
   logic [2:0] dbg_a, dbg_b;

   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   logic [7:0] sd_exp_a[$];
   logic [7:0] sd_exp_b[$];
   int         n_checks = 0;
   int         n_fail   = 0;

   vram_sam_gen dut_a (
      .MCLK(MCLK), .RESET_n(RESET_n), .RAS(RAS), .CAS(CAS), .WE(WE), .OE(OE),
      .SC(SC), .SE(SE), .AD(AD), .RD_i(RD_i), .RD_o(rd_o_a), .RD_d(rd_d_a),
      .SD_o(sd_o_a), .SD_d(sd_d_a), .o_dbg_state(dbg_a)
   );

   vram_sam_gen #(.PREFETCH(0), .WPB_EN(0)) dut_b (
      .MCLK(MCLK), .RESET_n(RESET_n), .RAS(RAS), .CAS(CAS), .WE(WE), .OE(OE),
      .SC(SC), .SE(SE), .AD(AD), .RD_i(RD_i), .RD_o(rd_o_b), .RD_d(rd_d_b),
      .SD_o(sd_o_b), .SD_d(sd_d_b), .o_dbg_state(dbg_b)
   );

   // Clock and watchdog.
   initial MCLK = 1'b0;
   always #5 MCLK = ~MCLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge MCLK);
      #1;
   endtask

   // Driver tasks.
   task automatic do_write(input logic [7:0] row, input logic [7:0] col, input logic [7:0] data,
                           input logic wpb, input logic [7:0] mask);
      RAS = 1'b0; AD = row; WE = ~wpb; OE = 1'b1; RD_i = mask;
      tick(1);
      AD = col; CAS = 1'b0; WE = 1'b0; RD_i = data;
      tick(5);
      CAS = 1'b1; RAS = 1'b1; WE = 1'b1;
      tick(2);
   endtask

   task automatic do_read(input logic [7:0] row, input logic [7:0] col, input string name);
      logic       got;
      logic [7:0] ea, eb;
      RAS = 1'b0; AD = row; WE = 1'b1; OE = 1'b1;
      tick(1);
      AD = col; CAS = 1'b0; OE = 1'b0;
      tick(1);
      got = 1'b0;
      for (int i = 0; i < 3 && !got; i++) begin
         tick(1);
         if (!rd_d_a && !rd_d_b) got = 1'b1;
      end
      ea = exp_a.pop_front();
      eb = exp_b.pop_front();
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL %s_valid: RD_d a=%0b b=%0b, required 0 within 3 MCLK", name, rd_d_a, rd_d_b);
      end
      n_checks++;
      if (rd_o_a !== ea) begin
         n_fail++;
         $display("FAIL %s_data_a: RD_o=%02h required %02h", name, rd_o_a, ea);
      end
      n_checks++;
      if (rd_o_b !== eb) begin
         n_fail++;
         $display("FAIL %s_data_b: RD_o=%02h required %02h", name, rd_o_b, eb);
      end
      CAS = 1'b1;
      tick(1);
      n_checks++;
      if (rd_d_a !== 1'b1 || rd_d_b !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_release: RD_d a=%0b b=%0b required 1", name, rd_d_a, rd_d_b);
      end
      RAS = 1'b1; OE = 1'b1;
      tick(2);
   endtask

   task automatic do_xfer(input logic [7:0] row, input logic [7:0] col, input logic collide,
                          input logic [7:0] hold);
      RAS = 1'b0; AD = row; OE = 1'b0; WE = 1'b1;
      tick(1);
      AD = col; CAS = 1'b0;
      tick(1);
      OE = 1'b1; SC = collide;
      tick(1);
      if (collide) begin
         n_checks++;
         if (sd_o_a !== hold || sd_o_b !== hold) begin
            n_fail++;
            $display("FAIL collision_hold: SD_o a=%02h b=%02h required %02h", sd_o_a, sd_o_b, hold);
         end
      end
      SC = 1'b0; CAS = 1'b1; RAS = 1'b1;
      tick(4);
   endtask

   task automatic sc_pulse(input string name);
      logic [7:0] ea, eb;
      SC = 1'b1;
      tick(1);
      ea = sd_exp_a.pop_front();
      eb = sd_exp_b.pop_front();
      n_checks++;
      if (sd_o_a !== ea) begin
         n_fail++;
         $display("FAIL %s_sd_a: SD_o=%02h required %02h", name, sd_o_a, ea);
      end
      n_checks++;
      if (sd_o_b !== eb) begin
         n_fail++;
         $display("FAIL %s_sd_b: SD_o=%02h required %02h", name, sd_o_b, eb);
      end
      SC = 1'b0;
      tick(4);
   endtask

   // Scenarios.
   task automatic test_reset();
      #2;
      n_checks++;
      if (rd_o_a !== 8'h00 || rd_d_a !== 1'b1 || sd_o_a !== 8'h00 ||
          rd_o_b !== 8'h00 || rd_d_b !== 1'b1 || sd_o_b !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: a RD_o=%02h RD_d=%0b SD_o=%02h b RD_o=%02h RD_d=%0b SD_o=%02h required 00/1/00",
                  rd_o_a, rd_d_a, sd_o_a, rd_o_b, rd_d_b, sd_o_b);
      end
      SE = 1'b1;
      #1;
      n_checks++;
      if (sd_d_a !== 1'b1 || sd_d_b !== 1'b1) begin
         n_fail++;
         $display("FAIL sd_d_follow_se: SD_d a=%0b b=%0b required 1", sd_d_a, sd_d_b);
      end
      SE = 1'b0;
      #1;
      n_checks++;
      if (sd_d_a !== 1'b0 || sd_d_b !== 1'b0) begin
         n_fail++;
         $display("FAIL sd_d_follow_se: SD_d a=%0b b=%0b required 0", sd_d_a, sd_d_b);
      end
      tick(2);
      RESET_n = 1'b1;
      tick(2);
      n_checks++;
      if (dbg_a !== 3'(ST_IDLE) || dbg_b !== 3'(ST_IDLE) || rd_d_a !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_idle: state a=%0d b=%0d RD_d=%0b required 0/0/1", dbg_a, dbg_b, rd_d_a);
      end
   endtask

   task automatic test_write_read();
      do_write(8'h12, 8'h34, 8'h5A, 1'b0, 8'h00);
      do_write(8'hAB, 8'hCD, 8'h3C, 1'b0, 8'h00);
      exp_a.push_back(8'h5A); exp_b.push_back(8'h5A);
      do_read(8'h12, 8'h34, "wr_rd_1234");
      exp_a.push_back(8'h3C); exp_b.push_back(8'h3C);
      do_read(8'hAB, 8'hCD, "wr_rd_abcd");
      exp_a.push_back(8'h5A); exp_b.push_back(8'h5A);
      do_read(8'h12, 8'h34, "wr_rd_reread");
   endtask

   task automatic test_wpb();
      do_write(8'h12, 8'h35, 8'hFF, 1'b0, 8'h00);
      do_write(8'h12, 8'h35, 8'h00, 1'b1, 8'h0F);
      exp_a.push_back(8'hF0);
      exp_b.push_back(8'h00);
      do_read(8'h12, 8'h35, "wpb");
   endtask

   task automatic test_transfer_prefetch();
      for (int i = 0; i < 8; i++)
         do_write(8'h12, 8'h30 + 8'(i), 8'h10 + 8'(i), 1'b0, 8'h00);
      do_xfer(8'h12, 8'h32, 1'b0, 8'h00);
      for (int i = 0; i < 6; i++) begin
         sd_exp_a.push_back(8'h12 + 8'(i));
         sd_exp_b.push_back(8'h10 + 8'((2 + i) % 4));
         sc_pulse("xfer_pf");
      end
   endtask

   task automatic test_row_wrap();
      for (int i = 0; i < 4; i++)
         do_write(8'h12, 8'hFC + 8'(i), 8'hA0 + 8'(i), 1'b0, 8'h00);
      do_write(8'h12, 8'h00, 8'hB0, 1'b0, 8'h00);
      do_write(8'h13, 8'h00, 8'hC3, 1'b0, 8'h00);
      do_xfer(8'h12, 8'hFE, 1'b0, 8'h00);
      sd_exp_a.push_back(8'hA2); sd_exp_b.push_back(8'hA2);
      sc_pulse("row_wrap_0");
      sd_exp_a.push_back(8'hA3); sd_exp_b.push_back(8'hA3);
      sc_pulse("row_wrap_1");
      sd_exp_a.push_back(8'hB0); sd_exp_b.push_back(8'hA0);
      sc_pulse("row_wrap_2");
      exp_a.push_back(8'hC3); exp_b.push_back(8'hC3);
      do_read(8'h13, 8'h00, "row13_untouched");
   endtask

   task automatic test_reset_mid_rmw();
      do_write(8'h20, 8'h00, 8'h11, 1'b0, 8'h00);
      RAS = 1'b0; AD = 8'h20; WE = 1'b1; OE = 1'b1;
      tick(1);
      AD = 8'h00; CAS = 1'b0; WE = 1'b0; RD_i = 8'h77;
      tick(2);
      n_checks++;
      if (dbg_a !== 3'(ST_RMW_WAIT) || dbg_b !== 3'(ST_RMW_WAIT)) begin
         n_fail++;
         $display("FAIL rmw_wait_state: state a=%0d b=%0d required %0d", dbg_a, dbg_b, ST_RMW_WAIT);
      end
      RESET_n = 1'b0;
      #1;
      n_checks++;
      if (rd_o_a !== 8'h00 || rd_d_a !== 1'b1 || sd_o_a !== 8'h00 ||
          rd_o_b !== 8'h00 || rd_d_b !== 1'b1 || sd_o_b !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_async: a RD_o=%02h RD_d=%0b SD_o=%02h b RD_o=%02h RD_d=%0b SD_o=%02h required 00/1/00",
                  rd_o_a, rd_d_a, sd_o_a, rd_o_b, rd_d_b, sd_o_b);
      end
      RAS = 1'b1; CAS = 1'b1; WE = 1'b1;
      tick(2);
      RESET_n = 1'b1;
      tick(2);
      exp_a.push_back(8'h11); exp_b.push_back(8'h11);
      do_read(8'h20, 8'h00, "rmw_discarded");
   endtask

   task automatic test_collision();
      do_xfer(8'h12, 8'h34, 1'b0, 8'h00);
      sd_exp_a.push_back(8'h14); sd_exp_b.push_back(8'h14);
      sc_pulse("coll_pre");
      do_xfer(8'h12, 8'h31, 1'b1, 8'h14);
      sd_exp_a.push_back(8'h11); sd_exp_b.push_back(8'h11);
      sc_pulse("coll_first");
   endtask

   initial begin
      RESET_n = 1'b0;
      RAS = 1'b1; CAS = 1'b1; WE = 1'b1; OE = 1'b1;
      SC = 1'b0; SE = 1'b0; AD = 8'h00; RD_i = 8'h00;
      test_reset();
      test_write_read();
      test_wpb();
      test_transfer_prefetch();
      test_row_wrap();
      test_reset_mid_rmw();
      test_collision();
      n_checks++;
      if (exp_a.size() + exp_b.size() + sd_exp_a.size() + sd_exp_b.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0",
                  exp_a.size() + exp_b.size() + sd_exp_a.size() + sd_exp_b.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
